// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK convolution window controller.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  // Number of windows presented per frame for a given geometry and stride.
  function automatic int unsigned win_count(input int unsigned k,
                                            input int unsigned w,
                                            input int unsigned h,
                                            input bit          stride2);
    int unsigned nr;
    int unsigned nc;
    nr = h - k + 1;
    nc = w - k + 1;
    if (stride2) begin
      nr = (nr + 1) / 2;
      nc = (nc + 1) / 2;
    end
    return nr * nc;
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster-order row/column position counter for the accepted pixel stream.
module pixel_pos_counter #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned CW    = $clog2(IMG_W),
  parameter int unsigned RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last_pix
);

  assign last_col = (col == CW'(IMG_W - 1));
  assign last_pix = last_col && (row == RW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the KxK line-buffer chain: drives sr_ce and flags complete windows.
// Optional macro CONV_WIN_STRIDE2_EN: present only even-anchored windows (stride 2).
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL = 3,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned CW     = $clog2(IMG_W),
  parameter int unsigned RW     = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sr_ce,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [RW-1:0] K_M1_R = RW'(KERNEL - 1);
  localparam logic [CW-1:0] K_M1_C = CW'(KERNEL - 1);

  conv_state_t   state_q;
  conv_state_t   state_d;
  logic          clr;
  logic          accept;
  logic          produce;
  logic          stride_ok;
  logic          last_col;
  logic          last_pix;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [RW-1:0] anchor_r;
  logic [CW-1:0] anchor_c;

  pixel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .clr      (clr),
    .row      (r),
    .col      (c),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // An unconsumed window freezes the whole chain.
  assign in_ready = (state_q == ST_RUN) && !(win_valid && !win_ready);
  assign accept   = in_valid && in_ready;
  assign sr_ce    = accept;

  assign anchor_r = r - K_M1_R;
  assign anchor_c = c - K_M1_C;

`ifdef CONV_WIN_STRIDE2_EN
  assign stride_ok = !anchor_r[0] && !anchor_c[0];
`else
  assign stride_ok = 1'b1;
`endif

  assign produce    = accept && (r >= K_M1_R) && (c >= K_M1_C) && stride_ok;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FLUSH exits once no window is pending or the last one is being consumed.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept && last_col && last_pix) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!win_valid || win_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (produce) begin
      win_valid <= 1'b1;
      win_row   <= anchor_r;
      win_col   <= anchor_c;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl on a 5x5 image with a 3x3 kernel.
module tb_conv_window_ctrl;

  localparam int unsigned K  = 3;
  localparam int unsigned W  = 5;
  localparam int unsigned H  = 5;
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned RW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          sr_ce;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_wins;
  int sr_cnt;
  int hs_cnt;
  int first_cnt;
  int cyc = 0;
  int last_hs_cyc;
  int done_cyc;
  bit seen_win;

  always #5 clk = ~clk;

  conv_window_ctrl #(
    .KERNEL (K),
    .IMG_W  (W),
    .IMG_H  (H),
    .CW     (CW),
    .RW     (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sr_ce      (sr_ce),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every window handshake.
  always @(negedge clk) begin
    int e;
    cyc++;
    if (rst && win_valid && !seen_win) begin
      seen_win  = 1'b1;
      first_cnt = sr_cnt;
    end
    if (sr_ce) sr_cnt++;
    if (win_valid && win_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("extra_window", int'(win_row) * 16 + int'(win_col), -1);
      end else begin
        e = exp_q.pop_front();
        check("win_coord", int'(win_row) * 16 + int'(win_col), e);
      end
    end
    if (frame_done) done_cyc = cyc;
  end

  task automatic push_expected();
`ifdef CONV_WIN_STRIDE2_EN
    exp_q.push_back(0 * 16 + 0);
    exp_q.push_back(0 * 16 + 2);
    exp_q.push_back(2 * 16 + 0);
    exp_q.push_back(2 * 16 + 2);
    exp_wins = 4;
`else
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        exp_q.push_back(r * 16 + c);
    exp_wins = 9;
`endif
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},   int'(in_ready),   0);
    check({tag, "_sr_ce"},      int'(sr_ce),      0);
    check({tag, "_win_valid"},  int'(win_valid),  0);
    check({tag, "_win_row"},    int'(win_row),    0);
    check({tag, "_win_col"},    int'(win_col),    0);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Runs one frame; entered and left at posedge+1.
  task automatic run_frame(input bit rand_v, input bit stall_en, input bit start_mid);
    int  t;
    int  stall_left;
    bit  stall_done;
    bit  got_done;
    seen_win    = 1'b0;
    sr_cnt      = 0;
    hs_cnt      = 0;
    last_hs_cyc = 0;
    done_cyc    = 0;
    stall_left  = 0;
    stall_done  = 1'b0;
    got_done    = 1'b0;
    exp_q.delete();
    push_expected();
    start     = 1'b1;
    in_valid  = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    check("start_pixel_rejected", int'(sr_ce), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    t = 0;
    while (!got_done && t < 400) begin
      in_valid = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (start_mid && t == 5);
      if (stall_en && !stall_done && win_valid && win_row == 1 && win_col == 1) begin
        stall_left = 4;
        stall_done = 1'b1;
      end
      win_ready = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_in_ready",  int'(in_ready),  0);
        check("stall_sr_ce",     int'(sr_ce),     0);
        check("stall_win_valid", int'(win_valid), 1);
        check("stall_coord", int'(win_row) * 16 + int'(win_col), 1 * 16 + 1);
        stall_left--;
      end
      if (frame_done) got_done = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    check("frame_done_seen", int'(got_done), 1);
    if (stall_en) check("stall_happened", int'(stall_done), 1);
    check("frame_done_pulse_width", int'(frame_done), 0);
    check("idle_after_done", int'(busy), 0);
    check("done_after_last_hs", done_cyc - last_hs_cyc, 1);
    check("window_count", hs_cnt, exp_wins);
    check("scoreboard_empty", exp_q.size(), 0);
    check("sr_ce_count", sr_cnt, 25);
    check("first_window_latency", first_cnt, 13);
  endtask

  initial begin
    int t;
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    sr_cnt    = 0;
    hs_cnt    = 0;
    seen_win  = 1'b0;
    exp_wins  = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      win_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle_zero("reset");
    end

    // Released with no start: must stay idle.
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_busy",     int'(busy),     0);
      check("idle_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end

    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);

    // Abort mid-frame after 10 pixels, then a full frame with a stray start.
    sr_cnt    = 0;
    start     = 1'b1;
    in_valid  = 1'b1;
    win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (sr_cnt < 10 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_reached_10", sr_cnt, 10);
    rst = 1'b0;
    #1;
    check_idle_zero("abort");
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencing controller for the KxK convolution line-buffer built from `shift_register` instances. It accepts a raster-order pixel stream and drives the shared `ce` of the shift-register chain. It tracks row and column position and flags each cycle on which the chain holds a complete KxK window for the downstream MAC array. Downstream back-pressure is honoured by freezing the chain.

## Interface
Parameters:
- `KERNEL`, 3, window side K; must satisfy 2 ≤ K ≤ min(`IMG_W`, `IMG_H`)
- `IMG_W`, 8, pixels per row
- `IMG_H`, 8, rows per frame
- `CW`, `$clog2(IMG_W)`, column counter width (derived)
- `RW`, `$clog2(IMG_H)`, row counter width (derived)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  frame start pulse; sampled only in IDLE
- `in_valid`  in  1  upstream pixel present
- `in_ready`  out  1  controller accepts pixel this cycle
- `sr_ce`  out  1  shift-register chain enable, equal to `in_valid & in_ready`
- `win_valid`  out  1  complete window present at chain taps
- `win_ready`  in  1  MAC array consumes window
- `win_row`  out  RW  top-left row of presented window
- `win_col`  out  CW  top-left column of presented window
- `busy`  out  1  high outside IDLE
- `frame_done`  out  1  one-cycle pulse after last window consumed

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE: `in_ready`=0. `start`=1 moves to RUN and clears row/col counters r, c.
- RUN: a pixel is accepted when `in_valid & in_ready`. The accepted pixel occupies position (r,c). Then c increments; at c=`IMG_W`-1, c wraps to 0 and r increments.
- `in_ready` = (state==RUN) & ~(`win_valid` & ~`win_ready`). A pending unconsumed window stalls the chain. Combinational path from `win_ready` is permitted.
- A window is produced when a pixel at (r,c) with r ≥ K-1 and c ≥ K-1 is accepted. On the next cycle `win_valid`=1, `win_row`=r-(K-1), `win_col`=c-(K-1).
- `win_valid` holds, with stable coordinates, until `win_valid & win_ready`. It clears that cycle unless a new window-producing pixel is accepted the same cycle, in which case it stays high with new coordinates.
- Accepting pixel (`IMG_H`-1, `IMG_W`-1) moves to FLUSH. `in_ready` is 0 in FLUSH.
- FLUSH: on the final window handshake move to DONE.
- DONE: `frame_done`=1 for exactly one cycle, then IDLE.
- Windows per frame: (`IMG_H`-K+1)·(`IMG_W`-K+1).
- `start` in RUN, FLUSH or DONE is ignored.

## Timing
- Reset values: state=IDLE, r=c=0, `in_ready`=0, `sr_ce`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `busy`=0, `frame_done`=0.
- Pixel-to-window latency: 1 cycle after the accepting edge, which matches the chain's registered output.
- Full throughput: one pixel per cycle while `win_ready`=1.
- Reset asserted mid-frame aborts immediately to reset values. The external chain contents are don't-care and are overwritten on the next frame.
- `start` and `in_valid` asserted in the same cycle in IDLE: the pixel is not accepted, because `in_ready` is 0 in IDLE.

## Configuration
- `CONV_WIN_STRIDE2_EN` defined: `win_valid` is raised only for windows whose `win_row` and `win_col` are both even. Pixels producing odd-anchor windows still shift, and do not stall.
- `CONV_WIN_STRIDE2_EN` undefined: stride 1, every window is presented.
- Frame end (FLUSH→DONE) always follows the handshake of the last presented window.

## Structure
- Shared `conv_pkg`: FSM state enum (IDLE/RUN/FLUSH/DONE), and a window-count function of K, W, H and stride.
- Sub-module `pixel_pos_counter`: raster row/col counter with `inc`, `clr`, `last_col`, `last_pix` outputs, instantiated once.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0, state IDLE. Release reset → stays idle until `start`.
- K=3, 5×5 image, `in_valid`=1, `win_ready`=1: first `win_valid` the cycle after the 13th accepted pixel (r2,c2) with coordinates (0,0). 9 windows total, `frame_done` 1 cycle after the last window handshake.
- Same setup, `win_ready`=0 for 4 cycles at window (1,1) → `in_ready`=0 and `sr_ce`=0 throughout, coordinates stable, and no pixel is lost.
- `in_valid` toggled 50% randomly → window order is raster (0,0)…(2,2) and the `sr_ce` count equals 25.
- `CONV_WIN_STRIDE2_EN`, 5×5, K=3 → exactly 4 windows: (0,0), (0,2), (2,0), (2,2).
- `rst` pulsed low after 10 pixels, then `start` again → full correct 9-window frame, and `start` during RUN has no effect.
